// File: rtl/audio_pkg.sv
// Shared constants and the gain-ramp state encoding for the PWM audio output stage.
package audio_pkg;
  localparam int SAMPLE_W = 8;
  localparam int MID      = 128;
  localparam int GAIN_ONE = 16;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    PLAY      = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_e;
endpackage

// File: rtl/pwm_audio_out_if.sv
// Sound-card side bus of the PWM output stage: sample/enable in, PWM bit and status out.
interface pwm_audio_out_if #(parameter int WIDTH = audio_pkg::SAMPLE_W);
  logic [WIDTH-1:0] sample;
  logic             enable;
  logic             pwm_out;
  logic             sample_tick;
  logic             active;

  modport master (output sample, enable, input pwm_out, sample_tick, active);
  modport slave  (input sample, enable, output pwm_out, sample_tick, active);
endinterface

// File: rtl/pwm_gain_ramp.sv
// Mute/unmute state machine; gain moves one step per PWM period between 0 and unity.
module pwm_gain_ramp
  import audio_pkg::*;
#(
  parameter int GAIN_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_i,
  input  logic               boundary_i,
  output logic [GAIN_BITS:0] gain_next_o,
  output ramp_state_e        state_o
);
  localparam int GW = GAIN_BITS + 1;
  localparam logic [GW-1:0] G_ONE = GW'(1 << GAIN_BITS);

  logic [GW-1:0] gain_q, gain_d;
  ramp_state_e   state_q, state_d;

  always_comb begin
    gain_d  = gain_q;
    state_d = state_q;
    case (state_q)
      MUTED: if (enable_i) begin
        gain_d  = GW'(1);
        state_d = RAMP_UP;
      end
      RAMP_UP, RAMP_DOWN: begin
        if (enable_i) begin
          gain_d  = gain_q + GW'(1);
          state_d = (gain_d == G_ONE) ? PLAY : RAMP_UP;
        end else begin
          gain_d  = gain_q - GW'(1);
          state_d = (gain_d == '0) ? MUTED : RAMP_DOWN;
        end
      end
      PLAY: begin
        if (enable_i) begin
          gain_d = G_ONE;
        end else begin
          gain_d  = G_ONE - GW'(1);
          state_d = RAMP_DOWN;
        end
      end
      default: begin
        gain_d  = '0;
        state_d = MUTED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gain_q  <= '0;
      state_q <= MUTED;
    end else if (boundary_i) begin
      gain_q  <= gain_d;
      state_q <= state_d;
    end
  end

  assign gain_next_o = gain_d;
  assign state_o     = state_q;
endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output: one offset-binary sample per 2**WIDTH-clock period, scaled by the ramp gain.
module pwm_audio_out
  import audio_pkg::*;
#(
  parameter int WIDTH     = SAMPLE_W,
  parameter int GAIN_BITS = 4
) (
  input  logic          clk,
  input  logic          reset,
  pwm_audio_out_if.slave bus
);
  localparam int DW    = WIDTH + 1;
  localparam int GW    = GAIN_BITS + 1;
  localparam int PW    = DW + GW;
  localparam int MID_L = 1 << (WIDTH - 1);

  logic [WIDTH-1:0]     cnt_q, duty_q, duty_d;
  logic                 pwm_q;
  logic                 boundary;
  logic [GW-1:0]        gain_next;
  ramp_state_e          state;
  logic signed [DW-1:0] diff;
  logic signed [PW-1:0] diff_x, gain_x, prod;

  assign boundary = (cnt_q == '1);

  pwm_gain_ramp #(.GAIN_BITS(GAIN_BITS)) u_ramp (
    .clk         (clk),
    .reset       (reset),
    .enable_i    (bus.enable),
    .boundary_i  (boundary),
    .gain_next_o (gain_next),
    .state_o     (state)
  );

  // Operands widened before the multiply so the product is formed at full width.
  assign diff   = $signed({1'b0, bus.sample}) - $signed(DW'(MID_L));
  assign diff_x = PW'(diff);
  assign gain_x = $signed(PW'(gain_next));
  assign prod   = diff_x * gain_x;
  // Arithmetic shift floors toward -inf, so the level always stays inside 0..2**WIDTH-1.
  assign duty_d = WIDTH'((prod >>> GAIN_BITS) + $signed(PW'(MID_L)));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      duty_q <= WIDTH'(MID_L);
      pwm_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + WIDTH'(1);
      pwm_q <= (cnt_q < duty_q);
      if (boundary) duty_q <= duty_d;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.sample_tick = boundary;
  assign bus.active      = (state != MUTED);
endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out: measures PWM high time per period against a queue of expected duties.
module tb_pwm_audio_out;
  import audio_pkg::*;

  typedef struct {
    int duty;
    bit act;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nchk = 0;
  int   nfail = 0;
  exp_t sb[$];

  pwm_audio_out_if #(.WIDTH(8)) bus ();

  pwm_audio_out #(.WIDTH(8), .GAIN_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // A window covers the 256 pwm_out values that follow one duty update.
  int acc = 0, len_cnt = 0, win_seq = 0, win_duty = 0, win_len = 0;
  bit tick_prev = 1'b0, act_at_tick = 1'b0, win_act = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      acc       <= 0;
      len_cnt   <= 0;
      tick_prev <= 1'b0;
    end else begin
      if (tick_prev) begin
        win_duty <= acc + int'(bus.pwm_out);
        win_len  <= len_cnt + 1;
        win_act  <= act_at_tick;
        win_seq  <= win_seq + 1;
        acc      <= 0;
        len_cnt  <= 0;
      end else begin
        acc     <= acc + int'(bus.pwm_out);
        len_cnt <= len_cnt + 1;
      end
      if (bus.sample_tick) act_at_tick <= bus.active;
      tick_prev <= bus.sample_tick;
    end
  end

  function automatic int dexp(int s, int g);
    return 128 + (((s - 128) * g) >>> 4);
  endfunction

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1; bus.enable = 1'b0; bus.sample = 8'd128;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    sb.delete();
    sb.push_back('{128, 1'b0});
  endtask

  // Drive s0/e0 now and s1/e1 100 clocks later, queue the duty expected for the
  // next period, then wait for the running period to end and return it.
  task automatic run_period(input logic [7:0] s0, input logic [7:0] s1, input logic e0,
                            input logic e1, input int exp_duty, input bit exp_act,
                            output exp_t ce, output int gd, output int gl,
                            output bit ga, output bit tmo);
    int start;
    bus.sample = s0; bus.enable = e0;
    sb.push_back('{exp_duty, exp_act});
    repeat (100) @(negedge clk);
    #1 bus.sample = s1; bus.enable = e1;
    start = win_seq;
    tmo = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (win_seq != start) begin tmo = 1'b0; break; end
    end
    ce = (sb.size() > 0) ? sb.pop_front() : '{-1, 1'b0};
    gd = win_duty; gl = win_len; ga = win_act;
  endtask

  task automatic test_reset();
    exp_t ce; int gd, gl; bit ga, tmo;
    reset = 1'b1; bus.enable = 1'b0; bus.sample = 8'd200;
    repeat (3) @(negedge clk);
    #1;
    nchk++; if (bus.pwm_out !== 1'b0) begin nfail++; $display("FAIL reset_pwm: got %b expected 0", bus.pwm_out); end
    nchk++; if (bus.sample_tick !== 1'b0) begin nfail++; $display("FAIL reset_tick: got %b expected 0", bus.sample_tick); end
    nchk++; if (bus.active !== 1'b0) begin nfail++; $display("FAIL reset_active: got %b expected 0", bus.active); end
    reset = 1'b0;
    sb.delete();
    sb.push_back('{128, 1'b0});
    for (int k = 0; k < 3; k++) begin
      run_period(8'd200, 8'd200, 1'b0, 1'b0, 128, 1'b0, ce, gd, gl, ga, tmo);
      nchk++; if (tmo || gd !== ce.duty) begin nfail++; $display("FAIL mute_duty[%0d]: got %0d expected %0d tmo=%0d", k, gd, ce.duty, tmo); end
      nchk++; if (ga !== ce.act) begin nfail++; $display("FAIL mute_active[%0d]: got %0d expected %0d", k, ga, ce.act); end
      nchk++; if (gl !== 256) begin nfail++; $display("FAIL mute_period[%0d]: got %0d expected 256", k, gl); end
    end
  endtask

  task automatic test_ramp_up();
    exp_t ce; int gd, gl; bit ga, tmo;
    do_reset();
    for (int g = 1; g <= 16; g++) begin
      run_period(8'd255, 8'd255, 1'b1, 1'b1, dexp(255, g), 1'b1, ce, gd, gl, ga, tmo);
      nchk++; if (tmo || gd !== ce.duty) begin nfail++; $display("FAIL ramp_duty[%0d]: got %0d expected %0d tmo=%0d", g - 1, gd, ce.duty, tmo); end
      nchk++; if (ga !== ce.act) begin nfail++; $display("FAIL ramp_active[%0d]: got %0d expected %0d", g - 1, ga, ce.act); end
    end
  endtask

  task automatic test_play_levels();
    exp_t ce; int gd, gl; bit ga, tmo;
    logic [7:0] s0 [5] = '{8'd0, 8'd128, 8'd64, 8'd0,   8'd192};
    logic [7:0] s1 [5] = '{8'd0, 8'd128, 8'd64, 8'd192, 8'd192};
    int         ed [5] = '{0,    128,    64,    192,    192};
    for (int k = 0; k < 5; k++) begin
      run_period(s0[k], s1[k], 1'b1, 1'b1, ed[k], 1'b1, ce, gd, gl, ga, tmo);
      nchk++; if (tmo || gd !== ce.duty) begin nfail++; $display("FAIL play_duty[%0d]: got %0d expected %0d tmo=%0d", k, gd, ce.duty, tmo); end
      nchk++; if (ga !== ce.act) begin nfail++; $display("FAIL play_active[%0d]: got %0d expected %0d", k, ga, ce.act); end
    end
  endtask

  task automatic test_mute();
    exp_t ce; int gd, gl; bit ga, tmo;
    run_period(8'd255, 8'd255, 1'b1, 1'b1, 255, 1'b1, ce, gd, gl, ga, tmo);
    nchk++; if (tmo || gd !== ce.duty) begin nfail++; $display("FAIL mute_pre_duty: got %0d expected %0d tmo=%0d", gd, ce.duty, tmo); end
    run_period(8'd255, 8'd255, 1'b1, 1'b0, dexp(255, 15), 1'b1, ce, gd, gl, ga, tmo);
    nchk++; if (tmo || gd !== ce.duty) begin nfail++; $display("FAIL mute_drop_duty: got %0d expected %0d tmo=%0d", gd, ce.duty, tmo); end
    for (int g = 14; g >= -1; g--) begin
      run_period(8'd255, 8'd255, 1'b0, 1'b0, (g < 0) ? 128 : dexp(255, g), (g > 0), ce, gd, gl, ga, tmo);
      nchk++; if (tmo || gd !== ce.duty) begin nfail++; $display("FAIL down_duty[%0d]: got %0d expected %0d tmo=%0d", g, gd, ce.duty, tmo); end
      nchk++; if (ga !== ce.act) begin nfail++; $display("FAIL down_active[%0d]: got %0d expected %0d", g, ga, ce.act); end
      nchk++; if (gl !== 256) begin nfail++; $display("FAIL down_period[%0d]: got %0d expected 256", g, gl); end
    end
  endtask

  task automatic test_reverse();
    exp_t ce; int gd, gl; bit ga, tmo;
    logic en [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int   ed [8] = '{135,  143,  151,  159,  167,  159,  167,  175};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      run_period(8'd255, 8'd255, en[k], en[k], ed[k], 1'b1, ce, gd, gl, ga, tmo);
      nchk++; if (tmo || gd !== ce.duty) begin nfail++; $display("FAIL rev_duty[%0d]: got %0d expected %0d tmo=%0d", k, gd, ce.duty, tmo); end
      nchk++; if (ga !== ce.act) begin nfail++; $display("FAIL rev_active[%0d]: got %0d expected %0d", k, ga, ce.act); end
    end
  endtask

  task automatic test_mid_reset();
    exp_t ce; int gd, gl; bit ga, tmo;
    bit seen;
    do_reset();
    for (int g = 1; g <= 16; g++)
      run_period(8'd255, 8'd255, 1'b1, 1'b1, dexp(255, g), 1'b1, ce, gd, gl, ga, tmo);
    repeat (100) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #1;
    nchk++; if (bus.pwm_out !== 1'b0) begin nfail++; $display("FAIL midrst_pwm: got %b expected 0", bus.pwm_out); end
    nchk++; if (bus.active !== 1'b0) begin nfail++; $display("FAIL midrst_active: got %b expected 0", bus.active); end
    nchk++; if (bus.sample_tick !== 1'b0) begin nfail++; $display("FAIL midrst_tick: got %b expected 0", bus.sample_tick); end
    reset = 1'b0;
    sb.delete();
    sb.push_back('{128, 1'b0});
    run_period(8'd255, 8'd255, 1'b1, 1'b1, 135, 1'b1, ce, gd, gl, ga, tmo);
    nchk++; if (tmo || gd !== ce.duty) begin nfail++; $display("FAIL midrst_duty: got %0d expected %0d tmo=%0d", gd, ce.duty, tmo); end
    nchk++; if (ga !== ce.act) begin nfail++; $display("FAIL midrst_state: got %0d expected %0d", ga, ce.act); end
    // Hold reset across the boundary edge itself; it must win over the gain step.
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (bus.sample_tick) begin seen = 1'b1; break; end
    end
    nchk++; if (!seen) begin nfail++; $display("FAIL bndrst_wait: got no sample_tick expected one within 400 clocks"); end
    reset = 1'b1;
    @(negedge clk); #1;
    nchk++; if (bus.active !== 1'b0) begin nfail++; $display("FAIL bndrst_active: got %b expected 0", bus.active); end
    nchk++; if (bus.pwm_out !== 1'b0) begin nfail++; $display("FAIL bndrst_pwm: got %b expected 0", bus.pwm_out); end
    reset = 1'b0;
    sb.delete();
    sb.push_back('{128, 1'b0});
    for (int g = 1; g <= 3; g++) begin
      run_period(8'd255, 8'd255, 1'b1, 1'b1, dexp(255, g), 1'b1, ce, gd, gl, ga, tmo);
      nchk++; if (tmo || gd !== ce.duty) begin nfail++; $display("FAIL bndrst_duty[%0d]: got %0d expected %0d tmo=%0d", g - 1, gd, ce.duty, tmo); end
      nchk++; if (ga !== ce.act) begin nfail++; $display("FAIL bndrst_state[%0d]: got %0d expected %0d", g - 1, ga, ce.act); end
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.sample = 8'd128;
    test_reset();
    test_ramp_up();
    test_play_levels();
    test_mute();
    test_reverse();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2000000");
    $fatal(1, "watchdog expired");
  end
endmodule
